// File: rtl/cascaded_alu_pipe_if.sv
// Operand/result handshake bundle for cascaded_alu_pipe.
// The slave modport is the pipeline side, and the master modport is the source/consumer side.
interface cascaded_alu_pipe_if #(
    parameter int DATA_WIDTH = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH-1:0]     b;
    logic [2:0]                op_sel;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*DATA_WIDTH-1:0]   result;

    modport master (
        output in_valid, a, b, op_sel, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, a, b, op_sel, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/cascaded_alu_pipe.sv
// Two-stage in-order ALU pipeline: stage 1 does arithmetic, a multi-cycle multiply or a pack,
// and stage 2 does logic ops or a pass-through. Both the input and the output use valid/ready.
module cascaded_alu_pipe #(
    parameter int DATA_WIDTH  = 16,
    parameter int MUL_LAT     = 3,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cascaded_alu_pipe_if.slave     bus,
    output logic                   mul_busy,
    output logic [COUNT_WIDTH-1:0] done_count
);
    localparam int W     = DATA_WIDTH;
    localparam int W2    = 2 * DATA_WIDTH;
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [1:0] S1_EMPTY = 2'd0;
    localparam logic [1:0] S1_MUL   = 2'd1;
    localparam logic [1:0] S1_FULL  = 2'd2;

    function automatic logic [W2-1:0] stage1_op(input logic [2:0] op,
                                                input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W2-1:0] xe, ye, r;
        xe = {{W{1'b0}}, x};
        ye = {{W{1'b0}}, y};
        if (op[2]) begin
            r = {x, y};
        end else begin
            case (op[1:0])
                2'b00:   r = xe * ye;
                2'b01:   r = xe + ye;
                2'b10:   r = {{W{1'b0}}, x - y};
                default: r = xe + ye + W2'(1);
            endcase
        end
        return r;
    endfunction

    function automatic logic [W2-1:0] stage2_op(input logic [2:0] op, input logic [W2-1:0] s);
        logic [W-1:0]  hi, lo;
        logic [W2-1:0] r;
        hi = s[W2-1:W];
        lo = s[W-1:0];
        if (!op[2]) begin
            r = s;
        end else begin
            case (op[1:0])
                2'b00:   r = {{W{1'b0}}, hi | lo};
                2'b01:   r = {{W{1'b0}}, hi & lo};
                2'b10:   r = {{W{1'b0}}, hi ^ lo};
                default: r = {~hi, ~lo};
            endcase
        end
        return r;
    endfunction

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [W-1:0]           opa_q, opa_d, opb_q, opb_d;
    logic [2:0]             op_q, op_d;
    logic [W2-1:0]          s1_res_q, s1_res_d;
    logic [W2-1:0]          s2_res_q, s2_res_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [COUNT_WIDTH-1:0] done_q, done_d;
    logic                   s1_adv, accept, out_take;

    always_comb begin
        s1_adv       = (state_q == S1_FULL) && (!s2_valid_q || bus.out_ready);
        bus.in_ready = rst_n && ((state_q == S1_EMPTY) || s1_adv);
        accept       = bus.in_valid && bus.in_ready;
        out_take     = s2_valid_q && bus.out_ready;

        state_d    = state_q;
        cnt_d      = cnt_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        op_d       = op_q;
        s1_res_d   = s1_res_q;
        s2_res_d   = s2_res_q;
        s2_valid_d = s2_valid_q;
        done_d     = done_q;

        case (state_q)
            S1_MUL: begin
                if (cnt_q == '0) begin
                    s1_res_d = stage1_op(3'b000, opa_q, opb_q);
                    state_d  = S1_FULL;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S1_FULL: if (s1_adv) state_d = S1_EMPTY;
            default: ;
        endcase

        // A new accept overrides the FULL->EMPTY drain, so back-to-back ops see no bubble.
        if (accept) begin
            op_d = bus.op_sel;
            if (bus.op_sel == 3'b000 && MUL_LAT > 1) begin
                state_d = S1_MUL;
                cnt_d   = CNT_W'(MUL_LAT - 1);
                opa_d   = bus.a;
                opb_d   = bus.b;
            end else begin
                state_d  = S1_FULL;
                s1_res_d = stage1_op(bus.op_sel, bus.a, bus.b);
            end
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_res_d   = stage2_op(op_q, s1_res_q);
        end else if (out_take) begin
            s2_valid_d = 1'b0;
        end

        if (out_take) done_d = done_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S1_EMPTY;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= '0;
            s1_res_q   <= '0;
            s2_res_q   <= '0;
            s2_valid_q <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            op_q       <= op_d;
            s1_res_q   <= s1_res_d;
            s2_res_q   <= s2_res_d;
            s2_valid_q <= s2_valid_d;
            done_q     <= done_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.result    = s2_res_q;
    assign mul_busy      = (state_q == S1_MUL);
    assign done_count    = done_q;
endmodule

// File: tb/tb_cascaded_alu_pipe.sv
// Self-checking bench for cascaded_alu_pipe: directed vector table, hand sequences, random traffic
// scored against an arithmetic reference model.
module tb_cascaded_alu_pipe;
    localparam int W       = 16;
    localparam int MUL_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        mul_busy;
    logic [15:0] done_count;

    cascaded_alu_pipe_if #(.DATA_WIDTH(W)) bus ();

    cascaded_alu_pipe #(
        .DATA_WIDTH (W),
        .MUL_LAT    (MUL_LAT),
        .COUNT_WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mul_busy  (mul_busy),
        .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: plain arithmetic on wide integers, then the high/low-half logic op.
    function automatic logic [31:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic [2:0] op);
        longint unsigned x, hi, lo, r;
        longint unsigned aa, bb;
        aa = longint'(av);
        bb = longint'(bv);
        if (op[2]) x = aa * 65536 + bb;
        else if (op[1:0] == 2'd0) x = aa * bb;
        else if (op[1:0] == 2'd1) x = aa + bb;
        else if (op[1:0] == 2'd2) x = (aa + 65536 - bb) % 65536;
        else x = aa + bb + 1;
        hi = x / 65536;
        lo = x % 65536;
        if (!op[2]) r = x;
        else if (op[1:0] == 2'd0) r = hi | lo;
        else if (op[1:0] == 2'd1) r = hi & lo;
        else if (op[1:0] == 2'd2) r = hi ^ lo;
        else r = (65535 - hi) * 65536 + (65535 - lo);
        return r[31:0];
    endfunction

    logic [31:0] exp_q[$];
    int          n_take;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            n_take = 0;
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) chk("mon_unexpected_out", 1, 0);
                else chk("mon_result", bus.result, exp_q[0]);
                if (bus.out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    n_take++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.op_sel));
                chk("mon_inflight_le2", exp_q.size() <= 2, 1);
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op_sel    = '0;
        rst_n         = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_one(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] opv,
                            input logic [31:0] expv, input int explat, input string nm);
        bit got;
        int k;
        bus.in_valid  = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.op_sel    = opv;
        bus.out_ready = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.op_sel   = ~opv;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        if (!got) begin
            chk({nm, "_accept_timeout"}, 0, 1);
            return;
        end
        chk({nm, "_busy_after_accept"}, mul_busy, opv == 3'b000);
        got = 1'b0;
        k = 0;
        while (!got && k <= 20) begin
            if (opv == 3'b000 && k < MUL_LAT) begin
                chk({nm, "_mul_busy"}, mul_busy, 1);
                chk({nm, "_in_ready_low"}, bus.in_ready, 0);
            end
            if (bus.out_valid) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        chk({nm, "_latency"}, k, explat);
        chk({nm, "_result"}, bus.result, expv);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int idx, n_acc;
        bit inc, seen;

        tbl[0] = '{16'h0003, 16'h0004, 3'b000, 32'h0000000C, MUL_LAT + 1};
        tbl[1] = '{16'hFFFF, 16'h0001, 3'b001, 32'h00010000, 1};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 3'b011, 32'h0001FFFF, 1};
        tbl[3] = '{16'h0001, 16'h0002, 3'b010, 32'h0000FFFF, 1};
        tbl[4] = '{16'hF0F0, 16'h0FF0, 3'b100, 32'h0000FFF0, 1};
        tbl[5] = '{16'hF0F0, 16'h0FF0, 3'b101, 32'h000000F0, 1};
        tbl[6] = '{16'hF0F0, 16'h0FF0, 3'b110, 32'h0000FF00, 1};
        tbl[7] = '{16'hF0F0, 16'h0FF0, 3'b111, 32'h0F0FF00F, 1};

        // Reset state, checked while reset is still asserted.
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.op_sel    = '0;
        rst_n         = 1'b0;
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_mul_busy", mul_busy, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        do_reset();
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 8; i++)
            send_one(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp, tbl[i].lat,
                     $sformatf("vec%0d", i));

        // Six back-to-back adds with the output always ready.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = (i < 6);
            bus.a        = 16'(i + 1);
            bus.b        = 16'(i + 1);
            bus.op_sel   = 3'b001;
            @(negedge clk);
            if (i < 6) chk("stream_in_ready", bus.in_ready, 1);
            if (i >= 2) begin
                chk("stream_out_valid", bus.out_valid, 1);
                chk("stream_result", bus.result, 2 * (i - 1));
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("stream_drained", bus.out_valid, 0);
        chk("stream_done_count", done_count, 6);

        // Backpressure: out_ready low only lets two ops in.
        do_reset();
        idx = 0;
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (idx < 5);
            bus.a        = 16'(idx + 10);
            bus.b        = 16'(idx * 3);
            bus.op_sel   = 3'b001;
            @(negedge clk);
            inc = bus.in_valid && bus.in_ready;
            if (inc) n_acc++;
            @(posedge clk);
            #1;
            if (inc) idx++;
        end
        chk("bp_accepts", n_acc, 2);
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_result_held", bus.result, model(16'd10, 16'd0, 3'b001));
        bus.out_ready = 1'b1;
        for (int t = 0; t < 30 && (idx < 5 || exp_q.size() > 0); t++) begin
            bus.in_valid = (idx < 5);
            bus.a        = 16'(idx + 10);
            bus.b        = 16'(idx * 3);
            bus.op_sel   = 3'b001;
            @(negedge clk);
            inc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (inc) idx++;
        end
        bus.in_valid = 1'b0;
        chk("bp_all_accepted", idx, 5);
        chk("bp_queue_empty", exp_q.size(), 0);
        chk("bp_done_count", done_count, 5);

        // Reset one cycle into a multiply.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 16'd5;
        bus.b         = 16'd7;
        bus.op_sel    = 3'b000;
        @(negedge clk);
        chk("abort_accept_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy_before", mul_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_result", bus.result, 0);
        chk("abort_mul_busy", mul_busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || mul_busy) seen = 1'b1;
        end
        chk("abort_no_stale_out", seen, 0);
        chk("abort_done_count", done_count, 0);

        // Random traffic with random ops and random backpressure.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.a         = 16'($urandom);
            bus.b         = 16'($urandom);
            bus.op_sel    = 3'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_done_count", done_count, 16'(n_take));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
